// File: rtl/div_clk_monitor.sv
// div_clk_monitor: synchronises a divided clock, emits edge strobes, measures its period and tracks lock.
// Define DIV_CLK_MONITOR_DUTY_CHECK_EN to add high-time (duty-cycle) checking.
module div_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 8,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             loss,
  output logic             duty_err
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, LOST} state_t;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, sync, rise, fall;
  logic [CNT_W-1:0]       cnt_q, cnt_d, period_q, period_d;
  logic                   rise_pulse_q, fall_pulse_q, period_vld_q, period_vld_d;
  logic                   good_p, timeout, period_bad;
  state_t                 state_q;
  logic [GW-1:0]          good_q;
  logic                   locked_q, loss_q;
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], slow_clk};
    sync         = sync_q[SYNC_STAGES-1];
    rise         = sync & ~prev_q;
    fall         = ~sync & prev_q;
    cnt_d        = rise ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    period_vld_d = rise && state_q != SEARCH;
    period_d     = period_vld_d ? cnt_q : period_q;
    good_p       = (int'(cnt_q) + TOL >= EXP_PERIOD) && (int'(cnt_q) <= EXP_PERIOD + TOL);
    timeout      = cnt_q == CNT_W'(TIMEOUT) && !rise;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      period_vld_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= sync;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      rise_pulse_q <= rise;
      fall_pulse_q <= fall;
      period_vld_q <= period_vld_d;
    end
  end
`ifdef DIV_CLK_MONITOR_DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             duty_pend_q, duty_pend_d, duty_err_q, duty_bad;
  always_comb begin
    hcnt_d      = rise ? CNT_W'(1) : (sync && !(&hcnt_q) ? hcnt_q + 1'b1 : hcnt_q);
    duty_bad    = fall && !((int'(hcnt_q) + TOL >= EXP_PERIOD / 2) && (int'(hcnt_q) <= EXP_PERIOD / 2 + TOL));
    duty_pend_d = rise ? 1'b0 : (duty_pend_q | duty_bad);
    period_bad  = !good_p || duty_pend_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      duty_pend_q <= 1'b0;
      duty_err_q  <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      duty_pend_q <= duty_pend_d;
      duty_err_q  <= duty_bad;
    end
  end
  assign duty_err = duty_err_q;
`else
  assign period_bad = !good_p;
  assign duty_err   = 1'b0;
`endif
  // Decisions are taken on the internal rise; locked/loss decode the settled state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      loss_q   <= 1'b0;
    end else begin
      locked_q <= state_q == LOCKED;
      loss_q   <= state_q == LOST;
      case (state_q)
        SEARCH: if (rise) begin
          state_q <= ACQUIRE;
          good_q  <= '0;
        end
        ACQUIRE: if (rise) begin
          if (period_bad) good_q <= '0;
          else if (int'(good_q) + 1 >= LOCK_COUNT) begin
            state_q <= LOCKED;
            good_q  <= '0;
          end else good_q <= good_q + 1'b1;
        end else if (timeout) state_q <= SEARCH;
        LOCKED: if ((rise && period_bad) || timeout) state_q <= LOST;
        LOST: if (rise) begin
          state_q <= ACQUIRE;
          good_q  <= '0;
        end
        default: state_q <= SEARCH;
      endcase
    end
  end
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign locked     = locked_q;
  assign loss       = loss_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: directed table of slow-clock periods plus timeout, async-reset and duty sequences.
module tb_div_clk_monitor;
  logic       clk = 1'b0, rst_n = 1'b0, slow_clk = 1'b0;
  logic       rise_pulse, fall_pulse, period_vld, locked, loss, duty_err;
  logic [7:0] period;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_rise = 0, n_rise = 0, n_fall = 0, n_vld = 0, n_duty = 0, n_duty_bad = 0, n_vld_bad = 0;
  typedef struct {int hi; int lo; int per; int vld; bit lk; bit ls;} vec_t;
  vec_t tv[16];
  div_clk_monitor dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .period(period), .period_vld(period_vld), .locked(locked), .loss(loss), .duty_err(duty_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rise_pulse) begin n_rise <= n_rise + 1; last_rise <= cyc; end
    if (fall_pulse) n_fall <= n_fall + 1;
    if (period_vld) n_vld <= n_vld + 1;
    if (period_vld && !rise_pulse) n_vld_bad <= n_vld_bad + 1;
    if (duty_err) n_duty <= n_duty + 1;
    if (duty_err && !fall_pulse) n_duty_bad <= n_duty_bad + 1;
  end
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v);
    @(negedge clk);
    slow_clk = v;
  endtask
  task automatic run_vec(input int i);
    int r0, v0, d0;
    r0 = n_rise; v0 = n_vld; d0 = n_duty;
    for (int k = 0; k < tv[i].hi; k++) step(1'b1);
    for (int k = 0; k < tv[i].lo; k++) step(1'b0);
    #2;
    check($sformatf("vec%0d rise_count", i), n_rise - r0, 1);
    check($sformatf("vec%0d vld_count", i), n_vld - v0, tv[i].vld);
    check($sformatf("vec%0d period", i), int'(period), tv[i].per);
    check($sformatf("vec%0d locked", i), int'(locked), int'(tv[i].lk));
    check($sformatf("vec%0d loss", i), int'(loss), int'(tv[i].ls));
    check($sformatf("vec%0d duty_err_count", i), n_duty - d0, 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, " rise_pulse"}, int'(rise_pulse), 0);
    check({tag, " fall_pulse"}, int'(fall_pulse), 0);
    check({tag, " period"}, int'(period), 0);
    check({tag, " period_vld"}, int'(period_vld), 0);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " loss"}, int'(loss), 0);
    check({tag, " duty_err"}, int'(duty_err), 0);
  endtask
  initial begin
    int d0;
    tv[0]  = '{4, 4, 0,  0, 0, 0};
    tv[1]  = '{4, 4, 8,  1, 0, 0};
    tv[2]  = '{4, 4, 8,  1, 0, 0};
    tv[3]  = '{4, 4, 8,  1, 0, 0};
    tv[4]  = '{4, 4, 8,  1, 1, 0};
    tv[5]  = '{4, 5, 8,  1, 1, 0};
    tv[6]  = '{4, 3, 9,  1, 1, 0};
    tv[7]  = '{4, 4, 7,  1, 1, 0};
    tv[8]  = '{5, 5, 8,  1, 1, 0};
    tv[9]  = '{4, 4, 10, 1, 0, 1};
    tv[10] = '{4, 4, 8,  1, 0, 0};
    tv[11] = '{4, 4, 8,  1, 0, 0};
    tv[12] = '{4, 4, 8,  1, 0, 0};
    tv[13] = '{4, 4, 8,  1, 0, 0};
    tv[14] = '{4, 4, 8,  1, 1, 0};
    tv[15] = '{4, 4, 8,  1, 1, 0};
    #12;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) run_vec(i);
    while (cyc - last_rise < 28) begin @(negedge clk); #1; end
    check("timeout early locked", int'(locked), 1);
    check("timeout early loss", int'(loss), 0);
    while (cyc - last_rise < 36) begin @(negedge clk); #1; end
    check("timeout locked", int'(locked), 0);
    check("timeout loss", int'(loss), 1);
    check("fall total", n_fall, 16);
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) step(1'b1);
      for (int k = 0; k < 4; k++) step(1'b0);
    end
    #2;
    check("relock from lost", int'(locked), 1);
    check("relock loss clear", int'(loss), 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("async reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(i);
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    d0 = n_duty;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 6; k++) step(1'b1);
      for (int k = 0; k < 2; k++) step(1'b0);
    end
    for (int k = 0; k < 4; k++) step(1'b0);
    #2;
`ifdef DIV_CLK_MONITOR_DUTY_CHECK_EN
    check("duty err count", n_duty - d0, 8);
    check("duty locked", int'(locked), 0);
`else
    check("duty err count", n_duty - d0, 0);
    check("duty locked", int'(locked), 1);
`endif
    check("duty_err without fall_pulse", n_duty_bad, 0);
    check("period_vld without rise_pulse", n_vld_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
